// File: rtl/alu_share_ctrl.sv
// Two-requester sequencer for a single shared combinational ALU.
// Round-robin arbitration, one op in flight, registered valid/ready response.
module alu_share_ctrl #(
   parameter int WIDTH  = 32,
   parameter int OPW    = 4,
   parameter int MAX_OP = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_i,
   input  logic [OPW-1:0]   op0_i,
   input  logic [OPW-1:0]   op1_i,
   input  logic [WIDTH-1:0] a0_i,
   input  logic [WIDTH-1:0] a1_i,
   input  logic [WIDTH-1:0] b0_i,
   input  logic [WIDTH-1:0] b1_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rsp_valid_o,
   input  logic [1:0]       rsp_ready_i,
   output logic [WIDTH-1:0] rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_err_o,
   output logic [WIDTH-1:0] alu_in1_o,
   output logic [WIDTH-1:0] alu_in2_o,
   output logic [OPW-1:0]   alu_control_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_zero_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef struct packed {
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   state_t     state, state_nx;
   logic       pri;
   logic       owner;
   logic       win;
   logic       illegal;
   logic [1:0] owner_oh;
   req_t       req_r;
   req_t       req_win;

   // On contention the requester named by pri wins; otherwise the lone requester.
   assign win      = (req_i == 2'b11) ? pri : req_i[1];
   assign req_win  = win ? '{op: op1_i, a: a1_i, b: b1_i}
                         : '{op: op0_i, a: a0_i, b: b0_i};
   assign illegal  = (req_r.op > OPW'(MAX_OP));
   assign owner_oh = {owner, ~owner};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_i != 2'b00) state_nx = ISSUE;
         ISSUE:   state_nx = RESP;
         RESP:    if (rsp_ready_i[owner]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gnt_o         = 2'b00;
      rsp_valid_o   = 2'b00;
      alu_in1_o     = '0;
      alu_in2_o     = '0;
      alu_control_o = '0;
      case (state)
         ISSUE: begin
            gnt_o         = owner_oh;
            alu_in1_o     = req_r.a;
            alu_in2_o     = req_r.b;
            alu_control_o = req_r.op;
         end
         RESP:    rsp_valid_o = owner_oh;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri   <= 1'b0;
         owner <= 1'b0;
         req_r <= '0;
      end else if (state == IDLE && req_i != 2'b00) begin
         owner <= win;
         pri   <= ~win;
         req_r <= req_win;
      end
   end

   // Illegal codes never reach the response: the ALU output is ignored for them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_result_o <= '0;
         rsp_zero_o   <= 1'b0;
         rsp_err_o    <= 1'b0;
      end else if (state == ISSUE) begin
         rsp_result_o <= illegal ? '0 : alu_result_i;
         rsp_zero_o   <= illegal ? 1'b1 : alu_zero_i;
         rsp_err_o    <= illegal;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized scoreboard bench for alu_share_ctrl with a behavioural ALU attached.
module tb_alu_share_ctrl;

   localparam int WIDTH = 32;
   localparam int OPW   = 4;

   logic             clk, rst;
   logic [1:0]       req_i, gnt_o, rsp_valid_o, rsp_ready_i;
   logic [OPW-1:0]   op0_i, op1_i, alu_control_o;
   logic [WIDTH-1:0] a0_i, a1_i, b0_i, b1_i;
   logic [WIDTH-1:0] rsp_result_o, alu_in1_o, alu_in2_o, alu_result_i;
   logic             rsp_zero_o, rsp_err_o, alu_zero_i;

   alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW), .MAX_OP(9)) dut (
      .clk(clk), .rst(rst), .req_i(req_i),
      .op0_i(op0_i), .op1_i(op1_i), .a0_i(a0_i), .a1_i(a1_i), .b0_i(b0_i), .b1_i(b1_i),
      .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o),
      .alu_in1_o(alu_in1_o), .alu_in2_o(alu_in2_o), .alu_control_o(alu_control_o),
      .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             owner;
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             err;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   // ALU semantics: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu
   function automatic logic [WIDTH-1:0] alu_fn(logic [OPW-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return WIDTH'($signed(a) >>> b[4:0]);
         4'd8: return WIDTH'($signed(a) < $signed(b));
         4'd9: return WIDTH'(a < b);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb begin
      alu_result_i = alu_fn(alu_control_o, alu_in1_o, alu_in2_o);
      alu_zero_i   = (alu_result_i == '0);
   end

   function automatic exp_t ref_rsp(logic own, logic [OPW-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      exp_t e;
      e.owner = own;
      e.err   = (op > 4'd9);
      e.res   = e.err ? '0 : alu_fn(op, a, b);
      e.zero  = (e.res == '0);
      return e;
   endfunction

   function automatic logic pick(logic [1:0] r, logic p);
      if (r == 2'b11) return p;
      return (r == 2'b10);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 operation issued, 2 response offered.
   int               m_phase;
   logic             m_pri, m_owner;
   logic [OPW-1:0]   m_op;
   logic [WIDTH-1:0] m_a, m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_pri <= 1'b0; m_owner <= 1'b0;
         m_op <= '0; m_a <= '0; m_b <= '0;
         exp_q.delete();
      end else begin
         case (m_phase)
            0: if (req_i != 2'b00) begin
               m_owner <= pick(req_i, m_pri);
               m_pri   <= ~pick(req_i, m_pri);
               m_op    <= pick(req_i, m_pri) ? op1_i : op0_i;
               m_a     <= pick(req_i, m_pri) ? a1_i : a0_i;
               m_b     <= pick(req_i, m_pri) ? b1_i : b0_i;
               exp_q.push_back(ref_rsp(pick(req_i, m_pri),
                                       pick(req_i, m_pri) ? op1_i : op0_i,
                                       pick(req_i, m_pri) ? a1_i : a0_i,
                                       pick(req_i, m_pri) ? b1_i : b0_i));
               m_phase <= 1;
            end
            1: m_phase <= 2;
            default: if (rsp_ready_i[m_owner]) m_phase <= 0;
         endcase
      end
   end

   // Monitor: compares every cycle, pops the scoreboard on a response handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            chk("gnt", gnt_o, (m_phase == 1) ? {m_owner, ~m_owner} : 2'b00);
            chk("rsp_valid", rsp_valid_o, (m_phase == 2) ? {m_owner, ~m_owner} : 2'b00);
            chk("alu_control", alu_control_o, (m_phase == 1) ? m_op : '0);
            chk("alu_in1", alu_in1_o, (m_phase == 1) ? m_a : '0);
            chk("alu_in2", alu_in2_o, (m_phase == 1) ? m_b : '0);
            if (rsp_valid_o != 2'b00) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", 1, 0);
               end else begin
                  chk("rsp_owner", rsp_valid_o, exp_q[0].owner ? 2'b10 : 2'b01);
                  chk("rsp_result", rsp_result_o, exp_q[0].res);
                  chk("rsp_zero", rsp_zero_o, exp_q[0].zero);
                  chk("rsp_err", rsp_err_o, exp_q[0].err);
                  if (m_phase == 2 && rsp_ready_i[m_owner]) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   logic [1:0] pend;

   task automatic new_req(int n, bit allow_bad);
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] a, b;
      op = (allow_bad && $urandom_range(7) == 0) ? OPW'($urandom_range(15, 10)) : OPW'($urandom_range(9));
      a  = $urandom;
      b  = ($urandom_range(3) == 0) ? a : $urandom;
      if (n == 0) begin op0_i = op; a0_i = a; b0_i = b; end
      else        begin op1_i = op; a1_i = a; b1_i = b; end
   endtask

   // mode 0: random traffic and ready stalls; 1: both saturating, ready=11; 2: drain
   task automatic drive_step(int mode);
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         if (gnt_o[n]) begin
            pend[n]  = 1'b0;
            req_i[n] = 1'b0;
            new_req(n, 1'b1);
         end else if (!pend[n] && mode != 2 && (mode == 1 || $urandom_range(3) == 0)) begin
            new_req(n, 1'b1);
            pend[n]  = 1'b1;
            req_i[n] = 1'b1;
         end
      end
      if (mode == 0) rsp_ready_i = {$urandom_range(3) == 0, $urandom_range(3) == 0};
      else           rsp_ready_i = 2'b11;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || m_phase != 0 || pend != 2'b00) && k < 200) begin
         drive_step(2);
         k++;
      end
      chk("drain_timeout", k >= 200, 0);
   endtask

   initial begin
      int k;
      rst = 1'b1; req_i = 2'b00; rsp_ready_i = 2'b00; pend = 2'b00;
      op0_i = '0; op1_i = '0; a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_valid", rsp_valid_o, 0);
      chk("rst_result", rsp_result_o, 0);
      chk("rst_zero", rsp_zero_o, 0);
      chk("rst_err", rsp_err_o, 0);
      chk("rst_alu", {alu_in1_o, alu_control_o}, 0);
      @(negedge clk);
      rst = 1'b0;
      op0_i = 4'd0; a0_i = 32'd5; b0_i = 32'd7; req_i = 2'b01; pend = 2'b01;
      @(posedge clk); #1;
      chk("first_gnt", gnt_o, 2'b01);
      chk("first_ctl", alu_control_o, 0);
      @(posedge clk); #1;
      chk("first_result", rsp_result_o, 12);
      for (int i = 0; i < 250; i++) drive_step(0);
      for (int i = 0; i < 60;  i++) drive_step(1);
      for (int i = 0; i < 250; i++) drive_step(0);
      drain();

      // Abort an operation by reset while its response is being offered.
      @(negedge clk);
      op0_i = 4'd2; a0_i = 32'hFFFF_0000; b0_i = 32'h0F0F_0F0F; req_i = 2'b01; pend = 2'b01;
      rsp_ready_i = 2'b00;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (gnt_o[0]) begin req_i[0] = 1'b0; pend[0] = 1'b0; end
         if (rsp_valid_o[0]) break;
         k++;
      end
      chk("resp_timeout", k >= 20, 0);
      new_req(1, 1'b0);
      req_i[1] = 1'b1; pend[1] = 1'b1;
      rst = 1'b1;
      #1;
      chk("arst_valid", rsp_valid_o, 0);
      chk("arst_result", {rsp_result_o, rsp_zero_o, rsp_err_o}, 0);
      chk("arst_gnt", gnt_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready_i = 2'b11;
      @(posedge clk); #1;
      chk("gnt_after_rst", gnt_o, 2'b10);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
